// File: rtl/fcc_pkg.sv
`default_nettype none
// =============================================================================
// Module  : fcc_pkg
// Brief   : Shared sizes and scanner state encoding for the FCC neighbour scan.
// Revision: 1.0
// =============================================================================
package fcc_pkg;

    localparam int W       = 16;
    localparam int IDX_W   = 12;
    localparam int DU_LAT  = 3;
    localparam int DIST2_W = 40;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADQ = 3'd1,
        S_QCAP  = 3'd2,
        S_SCAN  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fcc_scan_align.sv
`default_nettype none
// =============================================================================
// Module  : fcc_scan_align
// Brief   : DEPTH-deep valid+index delay line matching the distance unit latency.
// Revision: 1.0
// =============================================================================
module fcc_scan_align #(
    parameter int DEPTH = 3,
    parameter int IW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_valid,
    input  logic [IW-1:0] i_idx,
    output logic          o_valid,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [DEPTH-1:0] r_valid;
    logic [IW-1:0]    r_idx [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_idx[i] <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_idx[0]   <= i_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];
    assign o_any   = |r_valid;

endmodule
`default_nettype wire

// File: rtl/fcc_neighbor_scan.sv
`default_nettype none
// =============================================================================
// Module  : fcc_neighbor_scan
// Brief   : Epsilon-neighbourhood query: streams all points through the distance
//           unit against one query point and emits matching indices.
// Revision: 1.0
// =============================================================================
module fcc_neighbor_scan
    import fcc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IDX_W-1:0]          query_idx,
    input  logic [IDX_W:0]            num_pts,
    input  logic [DIST2_W-1:0]        eps2,
    output logic                      busy,
    output logic                      done,
    output logic                      nb_valid,
    output logic [IDX_W-1:0]          nb_idx,
    output logic [IDX_W:0]            nb_count,
    output logic                      mem_rd_en,
    output logic [IDX_W-1:0]          mem_rd_addr,
    input  logic signed [W-1:0]       mem_x,
    input  logic signed [W-1:0]       mem_y,
    input  logic signed [W-1:0]       mem_z,
    output logic                      du_in_valid,
    output logic signed [W-1:0]       du_ax,
    output logic signed [W-1:0]       du_ay,
    output logic signed [W-1:0]       du_az,
    output logic signed [W-1:0]       du_bx,
    output logic signed [W-1:0]       du_by,
    output logic signed [W-1:0]       du_bz,
    input  logic [DIST2_W-1:0]        du_dist2
);

    state_t                r_state;
    logic [IDX_W-1:0]      r_qidx;
    logic [IDX_W:0]        r_num;
    logic [DIST2_W-1:0]    r_eps2;
    logic [IDX_W-1:0]      r_addr;
    logic                  r_rd_en;
    logic                  r_du_valid;
    logic [IDX_W-1:0]      r_du_idx;
    logic signed [W-1:0]   r_ax, r_ay, r_az;
    logic                  r_nb_valid;
    logic [IDX_W-1:0]      r_nb_idx;
    logic [IDX_W:0]        r_nb_count;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_al_valid;
    logic [IDX_W-1:0]      w_al_idx;
    logic                  w_al_any;
    logic                  w_match;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (({1'b0, r_addr} + 1'b1) == r_num);
    // The query point itself is never reported as its own neighbour.
    assign w_match  = w_al_valid && (du_dist2 <= r_eps2) && (w_al_idx != r_qidx);

    fcc_scan_align #(
        .DEPTH (DU_LAT),
        .IW    (IDX_W)
    ) u_align (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_accept),
        .i_valid (r_du_valid),
        .i_idx   (r_du_idx),
        .o_valid (w_al_valid),
        .o_idx   (w_al_idx),
        .o_any   (w_al_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_qidx     <= '0;
            r_num      <= '0;
            r_eps2     <= '0;
            r_addr     <= '0;
            r_rd_en    <= 1'b0;
            r_du_valid <= 1'b0;
            r_du_idx   <= '0;
            r_ax       <= '0;
            r_ay       <= '0;
            r_az       <= '0;
            r_nb_valid <= 1'b0;
            r_nb_idx   <= '0;
            r_nb_count <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_en    <= 1'b0;
            r_done     <= 1'b0;
            r_du_valid <= r_rd_en && (r_state == S_SCAN);
            r_du_idx   <= r_addr;
            r_nb_valid <= w_match;
            if (w_match) begin
                r_nb_idx   <= w_al_idx;
                r_nb_count <= r_nb_count + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_qidx     <= query_idx;
                        r_num      <= num_pts;
                        r_eps2     <= eps2;
                        r_nb_count <= '0;
                        r_busy     <= 1'b1;
                        r_rd_en    <= 1'b1;
                        r_addr     <= query_idx;
                        r_state    <= S_LOADQ;
                    end
                end
                S_LOADQ: r_state <= S_QCAP;
                S_QCAP: begin
                    r_ax <= mem_x;
                    r_ay <= mem_y;
                    r_az <= mem_z;
                    if (r_num == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= '0;
                        r_rd_en <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_rd_en <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!r_du_valid && !w_al_any) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign nb_valid    = r_nb_valid;
    assign nb_idx      = r_nb_idx;
    assign nb_count    = r_nb_count;
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_addr;
    assign du_in_valid = r_du_valid;
    assign du_ax       = r_ax;
    assign du_ay       = r_ay;
    assign du_az       = r_az;
    assign du_bx       = mem_x;
    assign du_by       = mem_y;
    assign du_bz       = mem_z;

endmodule
`default_nettype wire

// File: tb/tb_fcc_neighbor_scan.sv
`default_nettype none
// =============================================================================
// Module  : tb_fcc_neighbor_scan
// Brief   : Self-checking bench with point memory and distance unit models.
// Revision: 1.0
// =============================================================================
module tb_fcc_neighbor_scan;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [11:0]        query_idx;
    logic [12:0]        num_pts;
    logic [39:0]        eps2;
    logic               busy, done, nb_valid;
    logic [11:0]        nb_idx;
    logic [12:0]        nb_count;
    logic               mem_rd_en;
    logic [11:0]        mem_rd_addr;
    logic signed [15:0] mem_x, mem_y, mem_z;
    logic               du_in_valid;
    logic signed [15:0] du_ax, du_ay, du_az, du_bx, du_by, du_bz;
    logic [39:0]        du_dist2;

    logic signed [15:0] px [4096];
    logic signed [15:0] py [4096];
    logic signed [15:0] pz [4096];
    logic [39:0]        dpipe [3];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fcc_neighbor_scan dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .query_idx   (query_idx),
        .num_pts     (num_pts),
        .eps2        (eps2),
        .busy        (busy),
        .done        (done),
        .nb_valid    (nb_valid),
        .nb_idx      (nb_idx),
        .nb_count    (nb_count),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_x       (mem_x),
        .mem_y       (mem_y),
        .mem_z       (mem_z),
        .du_in_valid (du_in_valid),
        .du_ax       (du_ax),
        .du_ay       (du_ay),
        .du_az       (du_az),
        .du_bx       (du_bx),
        .du_by       (du_by),
        .du_bz       (du_bz),
        .du_dist2    (du_dist2)
    );

    function automatic longint sqd(input logic signed [15:0] ax, ay, az, bx, by, bz);
        longint dx, dy, dz;
        dx = longint'(ax) - longint'(bx);
        dy = longint'(ay) - longint'(by);
        dz = longint'(az) - longint'(bz);
        return dx*dx + dy*dy + dz*dz;
    endfunction

    function automatic longint d2pt(input int a, input int b);
        return sqd(px[a], py[a], pz[a], px[b], py[b], pz[b]);
    endfunction

    // Synchronous-read point memory and a fixed-latency distance unit.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_x <= px[mem_rd_addr];
            mem_y <= py[mem_rd_addr];
            mem_z <= pz[mem_rd_addr];
        end
        dpipe[0] <= 40'(sqd(du_ax, du_ay, du_az, du_bx, du_by, du_bz));
        dpipe[1] <= dpipe[0];
        dpipe[2] <= dpipe[1];
    end
    assign du_dist2 = dpipe[2];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_set(input int s);
        for (int i = 0; i < 4096; i++) begin
            px[i] = 0; py[i] = 0; pz[i] = 0;
        end
        case (s)
            0: begin
                px[1] = 3; py[1] = 4;
                px[2] = 10;
                pz[3] = -5;
            end
            1: begin
                px[0] = -32768; py[0] = -32768; pz[0] = -32768;
                px[1] = 32767;  py[1] = 32767;  pz[1] = 32767;
            end
            default: begin
                for (int i = 0; i < 8; i++) begin
                    px[i] = 7; py[i] = -3; pz[i] = 100;
                end
            end
        endcase
    endtask

    task automatic run_query(input int q, input int n, input logic [39:0] e, output int cnt);
        int  dc;
        int  k;
        bit  m;
        cnt = 0;
        for (int i = 0; i < n; i++)
            if (i != q && d2pt(q, i) <= longint'(e)) cnt++;
        dc = (n == 0) ? 3 : n + 8;
        @(negedge clk);
        query_idx = 12'(q);
        num_pts   = 13'(n);
        eps2      = e;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= dc + 2; c++) begin
            k = c - 8;
            m = (k >= 0 && k < n && k != q && d2pt(q, k) <= longint'(e));
            check("nb_valid", longint'(nb_valid), longint'(m));
            if (m) check("nb_idx", longint'(nb_idx), longint'(k));
            check("done", longint'(done), longint'(c == dc));
            check("busy", longint'(busy), longint'(c <= dc));
            check("du_in_valid", longint'(du_in_valid), longint'(c >= 4 && c <= n + 3));
            check("mem_rd_en", longint'(mem_rd_en), longint'(c == 1 || (c >= 3 && c <= n + 2)));
            if (c == 1)
                check("rd_addr_query", longint'(mem_rd_addr), longint'(q));
            else if (c >= 3 && c <= n + 2)
                check("rd_addr_scan", longint'(mem_rd_addr), longint'(c - 3));
            if (c == 3)
                check("du_ax_latched", longint'(du_ax), longint'(px[q]));
            if (c >= dc)
                check("nb_count", longint'(nb_count), longint'(cnt));
            @(negedge clk);
        end
    endtask

    typedef struct {
        int          pset;
        int          q;
        int          n;
        logic [39:0] e;
        int          exp_cnt;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int cnt;
        tbl[0] = '{0, 0, 4, 40'd25, 2};
        tbl[1] = '{0, 0, 4, 40'd24, 0};
        tbl[2] = '{0, 0, 0, 40'd25, 0};
        tbl[3] = '{1, 0, 2, 40'hFF_FFFF_FFFF, 1};
        tbl[4] = '{1, 0, 2, 40'd12884508675, 1};
        tbl[5] = '{1, 0, 2, 40'd12884508674, 0};
        tbl[6] = '{2, 5, 8, 40'd0, 7};
        tbl[7] = '{0, 7, 4, 40'd100, 4};
        tbl[8] = '{0, 1, 4, 40'd25, 1};

        for (int i = 0; i < 3; i++) dpipe[i] = '0;
        mem_x = 0; mem_y = 0; mem_z = 0;
        rst = 1'b1; start = 1'b0; query_idx = '0; num_pts = '0; eps2 = '0;
        load_set(0);
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_nb_valid", longint'(nb_valid), 0);
        check("rst_nb_count", longint'(nb_count), 0);
        check("rst_mem_rd_en", longint'(mem_rd_en), 0);
        check("rst_du_in_valid", longint'(du_in_valid), 0);
        rst = 1'b0;

        for (int t = 0; t < 9; t++) begin
            load_set(tbl[t].pset);
            run_query(tbl[t].q, tbl[t].n, tbl[t].e, cnt);
            check("table_count", longint'(nb_count), longint'(tbl[t].exp_cnt));
        end

        // Reset in the middle of a 4-point query, after the first neighbour.
        load_set(0);
        @(negedge clk);
        query_idx = 12'd0; num_pts = 13'd4; eps2 = 40'd25; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_nb_valid", longint'(nb_valid), 1);
        check("pre_rst_nb_idx", longint'(nb_idx), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_nb_valid", longint'(nb_valid), 0);
        check("midrst_nb_idx", longint'(nb_idx), 0);
        check("midrst_nb_count", longint'(nb_count), 0);
        check("midrst_mem_rd_en", longint'(mem_rd_en), 0);
        check("midrst_mem_rd_addr", longint'(mem_rd_addr), 0);
        check("midrst_du_in_valid", longint'(du_in_valid), 0);
        check("midrst_du_ax", longint'(du_ax), 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_rst_nb_valid", longint'(nb_valid), 0);
            check("post_rst_done", longint'(done), 0);
        end
        run_query(0, 4, 40'd25, cnt);
        check("post_rst_count", longint'(nb_count), 2);

        // Randomised queries over small coordinates so matches are common.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 64; i++) begin
                px[i] = 16'($signed($urandom_range(0, 40)) - 20);
                py[i] = 16'($signed($urandom_range(0, 40)) - 20);
                pz[i] = 16'($signed($urandom_range(0, 40)) - 20);
            end
            run_query(int'($urandom_range(0, 45)), int'($urandom_range(1, 40)),
                      40'($urandom_range(0, 800)), cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
